clip_controller: RTL
====================

# clip_controller

Consumer-side control block for the clip recorder. It takes the synchronized 5-bit button/switch bus produced by the input synchronizer and debounces the three push-buttons into single-cycle press events. It runs the IDLE/RECORD/PLAY state machine and generates sample-rate write/read strobes and addresses for the two-clip sample memory. It also tracks the recorded length and validity of each clip.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive cycles a button level must differ from its debounced value before the debounced value changes (≥2).
- ADDR_WIDTH, 8: per-clip offset width; clip depth DEPTH = 2**ADDR_WIDTH samples.
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared immediately on assertion.
- q  in  5  synchronized bus {soft_reset_btn, record_btn, play_btn, clip_sel_wr, clip_sel_rd} (bit 4 down to bit 0).
- sample_tick  in  1  one-cycle strobe at the audio sample rate.
- mem_we  out  1  registered write strobe, one cycle per recorded sample.
- mem_re  out  1  registered read strobe, one cycle per played sample.
- mem_addr  out  ADDR_WIDTH+1  {clip, offset}; valid while mem_we or mem_re is high.
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY (11 unused).
- rec_led, play_led  out  1 each  state==RECORD, state==PLAY.
- clip_valid  out  2  bit n set = clip n holds a finished recording.

## Operation
- Debounce bits 4:2 independently with one counter each. The counter increments on each edge where raw != debounced and clears on any edge where raw == debounced. On reaching DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
- Press pulse: registered, high for one cycle after the debounced value rises. Falling edges generate nothing.
- Bits 1:0 are used undebounced. They are sampled only at operation start and latched as wclip/rclip.
- Per-clip length registers len0/len1 are ADDR_WIDTH+1 bits wide (range 0..DEPTH).
- IDLE:
  - Record press → RECORD. Latch wclip=q[1], clear offset, len[wclip] and clip_valid[wclip].
  - Else play press with clip_valid[q[0]]=1 → PLAY. Latch rclip=q[0], clear offset.
  - Play press on an invalid clip is ignored.
  - Record and play pressed in the same cycle: record wins.
- RECORD:
  - Each sample_tick: mem_we=1 and mem_addr={wclip,offset} next cycle; offset++ and len[wclip]++.
  - The tick completing the DEPTH-th write → IDLE on the same edge; clip_valid[wclip] set.
  - Record press → IDLE; clip_valid[wclip] set iff len[wclip] > 0.
  - Play press is ignored.
  - Tick and record press in the same cycle: the write is issued, then stop.
- PLAY:
  - Each sample_tick: mem_re=1 and mem_addr={rclip,offset} next cycle; offset++.
  - Tick issuing offset == len[rclip]-1 → IDLE on the same edge.
  - Play press → IDLE with no further reads. Record press is ignored.
  - Tick and play press in the same cycle: the read is issued, then stop.
- Soft reset press (bit 4), in any state: → IDLE, clip_valid=00, len0=len1=0, mem_we=mem_re=0. Debouncers are not cleared. Soft reset takes priority over all other presses.
- Offset arithmetic is modulo DEPTH. The length register saturates at DEPTH because recording stops there.

## Timing
- Reset values: state=00, mem_we=0, mem_re=0, mem_addr=0, rec_led=0, play_led=0, clip_valid=00. Internal counters, lengths, offsets, latched clips and debounced levels are all 0.
- Button latency: count the first edge sampling the new level as edge 1.
  - Debounced value flips at edge DEBOUNCE_CYCLES.
  - Press pulse is high after edge DEBOUNCE_CYCLES+1.
  - state, rec_led and play_led change at edge DEBOUNCE_CYCLES+2.
- A level lasting fewer than DEBOUNCE_CYCLES edges produces no press.
- Strobe latency: sample_tick high at edge t → mem_we/mem_re and mem_addr valid after edge t; strobe drops after edge t+1 unless another tick arrives.
- A sample_tick during the cycle a press is being acted on in IDLE is ignored. The first access happens on the first tick after the state changes.
- All outputs are registered. Reset assertion mid-operation clears outputs asynchronously; the first state change after deassertion happens at the first clock edge.

## Test plan
Settings for all scenarios: DEBOUNCE_CYCLES=4, ADDR_WIDTH=3 (DEPTH=8).
- q[3] glitches high for 3 cycles → no state change. Then q[1]=1 and q[3] held high → state=01, rec_led=1 at edge 6.
- Record clip 1 with 5 ticks, then record press → 5 single-cycle mem_we pulses at mem_addr 8,9,10,11,12; state=00; clip_valid=10.
- Play clip 1 (q[0]=1), 6 ticks → mem_re pulses at addr 8..12; automatic return to IDLE after the 5th read; no 6th read.
- Record clip 0 with 9 ticks, no stop press → mem_we at addr 0..7; IDLE after the 8th write; 9th tick produces nothing; clip_valid=11.
- Play press with q[0]=0 and clip_valid=00 → stays IDLE. Record and play pressed in the same cycle → RECORD.
- During RECORD: drive reset low without clocking → all outputs 0 immediately. After recovery, record clip 0 (2 ticks, stop, clip_valid=01), then soft reset press → clip_valid=00, state=00.

Source files
------------

// File: rtl/clip_controller_if.sv
// rtl/clip_controller_if.sv - sample memory access bus of the clip recorder
// Registered write/read strobes plus {clip, offset} address.
interface clip_controller_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH:0]   mem_addr;

  modport master (
    output mem_we,
    output mem_re,
    output mem_addr
  );

  modport slave (
    input mem_we,
    input mem_re,
    input mem_addr
  );
endinterface

// File: rtl/clip_controller.sv
// rtl/clip_controller.sv - clip recorder control: button debounce, IDLE/RECORD/PLAY FSM, memory strobes
// Buttons q_i[4:2] become single-cycle presses; q_i[1:0] pick the write/read clip at operation start.
module clip_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_WIDTH      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [4:0]               q_i,
  input  logic                     sample_tick_i,
  clip_controller_if.master        mem_o,
  output logic [1:0]               state_o,
  output logic                     rec_led_o,
  output logic                     play_led_o,
  output logic [1:0]               clip_valid_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10
  } state_t;

  // Debounce: bit 2 = soft reset, bit 1 = record, bit 0 = play
  logic [2:0]       raw;
  logic [2:0]       db_q, db_d, db_prev_q, press_q;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];

  assign raw = q_i[4:2];

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (raw[i] != db_q[i]) begin
        if (db_cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic soft_press, rec_press, play_press;
  assign soft_press = press_q[2];
  assign rec_press  = press_q[1];
  assign play_press = press_q[0];

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  offset_q, offset_d;
  logic [ADDR_WIDTH:0]    len_q [2];
  logic [ADDR_WIDTH:0]    len_d [2];
  logic                   wclip_q, wclip_d, rclip_q, rclip_d;
  logic [1:0]             valid_q, valid_d;
  logic                   we_q, we_d, re_q, re_d;
  logic [ADDR_WIDTH:0]    addr_q, addr_d;
  logic                   rec_led_q, play_led_q;
  logic [ADDR_WIDTH:0]    rec_len;
  logic                   play_last;

  assign rec_len   = len_q[wclip_q] + 1'b1;
  assign play_last = (({1'b0, offset_q} + 1'b1) == len_q[rclip_q]);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    len_d[0] = len_q[0];
    len_d[1] = len_q[1];
    wclip_d  = wclip_q;
    rclip_d  = rclip_q;
    valid_d  = valid_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = addr_q;

    if (soft_press) begin
      state_d  = S_IDLE;
      valid_d  = 2'b00;
      len_d[0] = '0;
      len_d[1] = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rec_press) begin
            state_d         = S_RECORD;
            wclip_d         = q_i[1];
            offset_d        = '0;
            len_d[q_i[1]]   = '0;
            valid_d[q_i[1]] = 1'b0;
          end else if (play_press && valid_q[q_i[0]]) begin
            state_d  = S_PLAY;
            rclip_d  = q_i[0];
            offset_d = '0;
          end
        end
        S_RECORD: begin
          if (sample_tick_i) begin
            we_d           = 1'b1;
            addr_d         = {wclip_q, offset_q};
            offset_d       = offset_q + 1'b1;
            len_d[wclip_q] = rec_len;
            if (rec_len == LEN_FULL) begin
              state_d          = S_IDLE;
              valid_d[wclip_q] = 1'b1;
            end
          end
          // A write issued on the stop cycle still counts towards validity
          if (rec_press) begin
            state_d          = S_IDLE;
            valid_d[wclip_q] = sample_tick_i || (len_q[wclip_q] != '0);
          end
        end
        S_PLAY: begin
          if (sample_tick_i) begin
            re_d     = 1'b1;
            addr_d   = {rclip_q, offset_q};
            offset_d = offset_q + 1'b1;
            if (play_last) begin
              state_d = S_IDLE;
            end
          end
          if (play_press) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      offset_q   <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wclip_q    <= 1'b0;
      rclip_q    <= 1'b0;
      valid_q    <= 2'b00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      addr_q     <= '0;
      rec_led_q  <= 1'b0;
      play_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      wclip_q    <= wclip_d;
      rclip_q    <= rclip_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      re_q       <= re_d;
      addr_q     <= addr_d;
      rec_led_q  <= (state_d == S_RECORD);
      play_led_q <= (state_d == S_PLAY);
    end
  end

  assign mem_o.mem_we   = we_q;
  assign mem_o.mem_re   = re_q;
  assign mem_o.mem_addr = addr_q;
  assign state_o        = state_q;
  assign rec_led_o      = rec_led_q;
  assign play_led_o     = play_led_q;
  assign clip_valid_o   = valid_q;

endmodule
